// File: rtl/conv_out_packer_p.sv
// rtl/conv_out_packer_p.sv - packs masked P-lane conv results into dense raster words with eol/eof
// Optional build macro CONVPACK_SAT_EN: signed clamp to [0, 2^BITW-1] through one extra register stage.
module conv_out_packer_p #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int P      = 4,
  parameter int IBITW  = 20,
  parameter int BITW   = 8,
  parameter int DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [P-1:0]       in_valid_vec,
  input  logic [P*IBITW-1:0] in_res_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P*BITW-1:0]  out_pix_vec,
  output logic               out_eol,
  output logic               out_eof,
  output logic               ovf
);
  localparam int CW = $clog2(P) + 1;
  localparam int XW = $clog2(WIDTH) + 1;
  localparam int YW = $clog2(HEIGHT) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = P*BITW + 2;
  localparam int MW = 2*P*BITW;

  logic [P*BITW-1:0] cv_flat;
  logic              blk;
  logic              unused_res;

  assign blk        = in_valid & (|in_valid_vec);
  assign unused_res = ^in_res_vec;

  always_comb begin
    cv_flat = '0;
    for (int i = 0; i < P; i++) begin
`ifdef CONVPACK_SAT_EN
      if (in_res_vec[i*IBITW + IBITW-1])
        cv_flat[i*BITW +: BITW] = '0;
      else if (|in_res_vec[i*IBITW + BITW +: IBITW-BITW-1])
        cv_flat[i*BITW +: BITW] = '1;
      else
        cv_flat[i*BITW +: BITW] = in_res_vec[i*IBITW +: BITW];
`else
      cv_flat[i*BITW +: BITW] = in_res_vec[i*IBITW +: BITW];
`endif
    end
  end

  logic              st_blk;
  logic [P-1:0]      st_mask;
  logic [P*BITW-1:0] st_flat;

`ifdef CONVPACK_SAT_EN
  logic              sat_blk_q;
  logic [P-1:0]      sat_mask_q;
  logic [P*BITW-1:0] sat_flat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_blk_q  <= 1'b0;
      sat_mask_q <= '0;
      sat_flat_q <= '0;
    end else begin
      sat_blk_q  <= blk;
      sat_mask_q <= in_valid_vec;
      sat_flat_q <= cv_flat;
    end
  end

  assign st_blk  = sat_blk_q;
  assign st_mask = sat_mask_q;
  assign st_flat = sat_flat_q;
`else
  assign st_blk  = blk;
  assign st_mask = in_valid_vec;
  assign st_flat = cv_flat;
`endif

  logic [(P-1)*BITW-1:0] acc_q;
  logic [CW-1:0]         acc_cnt_q;
  logic [XW-1:0]         opix_q;
  logic [YW-1:0]         orow_q;
  logic                  pend_v_q;
  logic [FW-1:0]         pend_q;
  logic                  word_v_q;
  logic [FW-1:0]         word_q;

  int            k, acc_n, tot, opix_n;
  logic [MW-1:0] cmb;
  logic          row_end, last_row, full_w, flush_w;
  logic [FW-1:0] full_d, flush_d;

  // Accumulator lanes above acc_cnt_q are kept zero, so OR-merging is safe
  // and flush words come out with zeroed high lanes for free.
  always_comb begin
    k = 0;
    for (int j = 0; j < P; j++) k = k + (st_mask[j] ? 1 : 0);
    acc_n    = int'(acc_cnt_q);
    tot      = acc_n + k;
    opix_n   = int'(opix_q) + k;
    row_end  = st_blk && (opix_n >= WIDTH-2);
    last_row = (orow_q == YW'(HEIGHT-3));
    full_w   = st_blk && (tot >= P);
    flush_w  = row_end && (tot != P);
    cmb      = MW'(acc_q) | (MW'(st_flat >> (BITW*(P-k))) << (BITW*acc_n));
    full_d   = {row_end && !flush_w && last_row, row_end && !flush_w, cmb[P*BITW-1:0]};
    flush_d  = {last_row, 1'b1, (tot >= P) ? cmb[MW-1 -: P*BITW] : cmb[P*BITW-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      opix_q    <= '0;
      orow_q    <= '0;
      pend_v_q  <= 1'b0;
      pend_q    <= '0;
      word_v_q  <= 1'b0;
      word_q    <= '0;
    end else begin
      pend_v_q <= flush_w;
      if (flush_w) pend_q <= flush_d;
      // A pending flush never collides with a full word: a row's first block cannot fill one.
      word_v_q <= full_w | pend_v_q;
      if (full_w)        word_q <= full_d;
      else if (pend_v_q) word_q <= pend_q;
      if (st_blk) begin
        if (row_end) begin
          acc_q     <= '0;
          acc_cnt_q <= '0;
          opix_q    <= '0;
          orow_q    <= last_row ? '0 : orow_q + 1'b1;
        end else begin
          acc_cnt_q <= CW'((tot >= P) ? tot - P : tot);
          acc_q     <= (tot >= P) ? cmb[P*BITW +: (P-1)*BITW] : cmb[(P-1)*BITW-1:0];
          opix_q    <= XW'(opix_n);
        end
      end
    end
  end

  // FIFO: head register plus memory; capacity counts both.
  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   mcnt_q;
  logic [FW-1:0] head_q;
  logic          head_v_q, ovf_q;
  logic          pop, full, accept, load;

  always_comb begin
    pop    = head_v_q & out_ready;
    full   = ((AW+1)'(head_v_q) + mcnt_q) == (AW+1)'(DEPTH);
    accept = word_v_q & (~full | pop);
    load   = (~head_v_q | pop) & (mcnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_q] <= word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      mcnt_q   <= '0;
      head_q   <= '0;
      head_v_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (word_v_q & ~accept) ovf_q <= 1'b1;
      if (load) begin
        head_q   <= mem[rd_q];
        head_v_q <= 1'b1;
        rd_q     <= rd_q + 1'b1;
      end else if (pop) begin
        head_v_q <= 1'b0;
      end
      mcnt_q <= mcnt_q + (AW+1)'(accept) - (AW+1)'(load);
    end
  end

  assign out_valid   = head_v_q;
  assign out_pix_vec = head_q[P*BITW-1:0];
  assign out_eol     = head_q[P*BITW];
  assign out_eof     = head_q[P*BITW+1];
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_conv_out_packer_p.sv
// tb/tb_conv_out_packer_p.sv - directed self-checking bench for conv_out_packer_p
module tb_conv_out_packer_p;
  localparam int P = 4, WIDTH = 8, HEIGHT = 5, IBITW = 20, BITW = 8, DEPTH = 4;
`ifdef CONVPACK_SAT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [P-1:0]       in_valid_vec = '0;
  logic [P*IBITW-1:0] in_res_vec = '0;
  logic               out_ready = 1'b1;
  logic               out_valid, out_eol, out_eof, ovf;
  logic [P*BITW-1:0]  out_pix_vec;

  int          checks = 0, errors = 0, stall_err = 0;
  logic [33:0] got[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;

  always #5 clk = ~clk;

  conv_out_packer_p #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .P(P), .IBITW(IBITW), .BITW(BITW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_valid_vec(in_valid_vec),
    .in_res_vec(in_res_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix_vec(out_pix_vec), .out_eol(out_eol), .out_eof(out_eof), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!out_valid || {out_eof, out_eol, out_pix_vec} !== prev_word)) stall_err++;
      if (out_valid && out_ready) got.push_back({out_eof, out_eol, out_pix_vec});
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_eof, out_eol, out_pix_vec};
    end
  end

  function automatic logic [33:0] w_first(input int b);
    return {2'b00, 8'(b+3), 8'(b+2), 8'(b+1), 8'(b)};
  endfunction

  function automatic logic [33:0] w_last(input int b, input logic eof);
    return {eof, 1'b1, 16'h0, 8'(b+5), 8'(b+4)};
  endfunction

  function automatic logic [33:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_blk(input logic [3:0] mask, input int r0, input int r1, input int r2, input int r3);
    in_valid     = 1'b1;
    in_valid_vec = mask;
    in_res_vec   = {IBITW'(r3), IBITW'(r2), IBITW'(r1), IBITW'(r0)};
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_valid_vec = '0;
  endtask

  task automatic send_row(input int b);
    send_blk(4'b1100, 99, 99, b, b+1);
    send_blk(4'b1111, b+2, b+3, b+4, b+5);
  endtask

  task automatic check_frame(input string tag, input int b0, input int b1, input int b2);
    int bs[3];
    bs = '{b0, b1, b2};
    check({tag, "_count"}, 64'(got.size()), 64'd6);
    for (int r = 0; r < 3; r++) begin
      check($sformatf("%s_w%0d", tag, 2*r), 64'(got_at(2*r)), 64'(w_first(bs[r])));
      check($sformatf("%s_w%0d", tag, 2*r+1), 64'(got_at(2*r+1)), 64'(w_last(bs[r], r == 2)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pix", 64'(out_pix_vec), 64'd0);
    check("rst_eol", 64'(out_eol), 64'd0);
    check("rst_eof", 64'(out_eof), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // frame 1: row 0 carries the {3,2}/{7,6,5,4} example with exact latency
    got.delete();
    send_blk(4'b1100, 99, 99, 2, 3);
    send_blk(4'b1111, 4, 5, 6, 7);
    repeat (LAT-1) @(posedge clk);
    #1;
    check("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("ex_w0", 64'({out_eof, out_eol, out_pix_vec}), 64'(w_first(2)));
    @(posedge clk);
    #1;
    check("ex_w1", 64'({out_eof, out_eol, out_pix_vec}), 64'(w_last(2, 1'b0)));
    send_row(8'h20);
    send_row(8'h40);
    idle(12);
    check_frame("f1", 2, 8'h20, 8'h40);

    got.delete();
    send_row(8'h60);
    send_row(8'h70);
    send_row(8'h80);
    idle(12);
    check_frame("f2", 8'h60, 8'h70, 8'h80);

    // overflow with downstream stalled
    got.delete();
    out_ready = 1'b0;
    send_row(8'h90);
    send_row(8'hA0);
    send_row(8'hB0);
    idle(10);
    check("ovf_set", 64'(ovf), 64'd1);
    check("ovf_head_valid", 64'(out_valid), 64'd1);
    check("ovf_head", 64'({out_eof, out_eol, out_pix_vec}), 64'(w_first(8'h90)));
    check("ovf_no_pop", 64'(got.size()), 64'd0);
    out_ready = 1'b1;
    idle(12);
    check("ovf_count", 64'(got.size()), 64'd4);
    check("ovf_w0", 64'(got_at(0)), 64'(w_first(8'h90)));
    check("ovf_w1", 64'(got_at(1)), 64'(w_last(8'h90, 1'b0)));
    check("ovf_w2", 64'(got_at(2)), 64'(w_first(8'hA0)));
    check("ovf_w3", 64'(got_at(3)), 64'(w_last(8'hA0, 1'b0)));

    // out_ready toggling every cycle
    got.delete();
    stall_err = 0;
    fork
      begin
        send_row(8'hC0);
        idle(3);
        send_row(8'hD0);
        idle(3);
        send_row(8'hE0);
      end
      begin
        repeat (30) begin
          out_ready = ~out_ready;
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    idle(12);
    check_frame("tog", 8'hC0, 8'hD0, 8'hE0);
    check("tog_stable", 64'(stall_err), 64'd0);

    // reset during the third output row
    got.delete();
    out_ready = 1'b0;
    send_row(8'h10);
    send_row(8'h30);
    send_blk(4'b1100, 99, 99, 8'h50, 8'h51);
    idle(4);
    check("prerst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_pix", 64'(out_pix_vec), 64'd0);
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
    got.delete();
    send_row(8'h58);
    send_row(8'h68);
    send_row(8'h78);
    idle(12);
    check_frame("rst", 8'h58, 8'h68, 8'h78);

    // pixel conversion: 300, 17, -5, 1 then 2, 3
    got.delete();
    send_blk(4'b1100, 99, 99, 300, 17);
    send_blk(4'b1111, -5, 1, 2, 3);
    idle(12);
    check("conv_count", 64'(got.size()), 64'd2);
`ifdef CONVPACK_SAT_EN
    check("conv_w0", 64'(got_at(0)), 64'({2'b00, 32'h010011FF}));
`else
    check("conv_w0", 64'(got_at(0)), 64'({2'b00, 32'h01FB112C}));
`endif
    check("conv_w1", 64'(got_at(1)), 64'({2'b01, 32'h00000302}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
